// File: rtl/dma_pkg.sv
// Shared DMA definitions: bus widths, register map, field positions and the
// control FSM state type used by the register interface and the engine.
package dma_pkg;

    localparam int AddrW = 32;
    localparam int DataW = 32;

    localparam logic [7:0] SRC_OFFSET       = 8'h00;
    localparam logic [7:0] DST_OFFSET       = 8'h04;
    localparam logic [7:0] CONTROL_OFFSET   = 8'h08;
    localparam logic [7:0] CONDITION_OFFSET = 8'h0C;
    localparam logic [7:0] INTERRUPT_OFFSET = 8'h10;
    localparam logic [7:0] ACTIVATE_OFFSET  = 8'h14;
    localparam logic [7:0] STATUS_OFFSET    = 8'h18;

    localparam int CTRL_SIZE_BIT    = 16;
    localparam int COND_EN_BIT      = 0;
    localparam int COND_TYPE_BIT    = 1;
    localparam int IRQ_EN_BIT       = 0;
    localparam int IRQ_PENDING_BIT  = 1;
    localparam int STATUS_BUSY_BIT  = 0;
    localparam int STATUS_DONE_BIT  = 1;

    typedef enum logic {
        SIZE_WORD = 1'b0,
        SIZE_BYTE = 1'b1
    } transfer_size_t;

    typedef enum logic {
        COND_LEVEL = 1'b0,
        COND_EDGE  = 1'b1
    } condition_type_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        BUSY  = 2'd2
    } ctrl_state_t;

    // Replace only the byte lanes selected by the byte enables.
    function automatic logic [DataW-1:0] apply_be(input logic [DataW-1:0] old_word,
                                                  input logic [DataW-1:0] new_word,
                                                  input logic [DataW/8-1:0] be);
        logic [DataW-1:0] merged;
        merged = old_word;
        for (int b = 0; b < DataW / 8; b++) begin
            if (be[b]) merged[8*b +: 8] = new_word[8*b +: 8];
        end
        return merged;
    endfunction

    function automatic logic be_bit(input logic old_bit,
                                    input logic [DataW-1:0] new_word,
                                    input logic [DataW/8-1:0] be,
                                    input int pos);
        return be[pos/8] ? new_word[pos] : old_bit;
    endfunction

endpackage

// File: rtl/dma_reg_if.sv
// OBI register interface of the DMA: configuration registers, activation
// handshake with the engine, completion status and the interrupt line.
module dma_reg_if
    import dma_pkg::*;
#(
    parameter int LenW = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             req_i,
    output logic             gnt_o,
    input  logic [AddrW-1:0] addr_i,
    input  logic             we_i,
    input  logic [3:0]       be_i,
    input  logic [DataW-1:0] wdata_i,
    output logic             rvalid_o,
    output logic [DataW-1:0] rdata_o,
    output logic             err_o,
    output logic [AddrW-1:0] src_addr_o,
    output logic [AddrW-1:0] dst_addr_o,
    output logic [LenW-1:0]  len_o,
    output transfer_size_t   size_o,
    output logic             cond_en_o,
    output condition_type_t  cond_type_o,
    output logic             start_o,
    input  logic             done_i,
    output logic             irq_o
);

    logic [AddrW-1:0] src_q, dst_q;
    logic [LenW-1:0]  len_q;
    transfer_size_t   size_q;
    logic             cond_en_q;
    condition_type_t  cond_type_q;
    logic             irq_en_q, irq_pending_q, done_q, irq_q;
    ctrl_state_t      state_q, state_d;
    logic             rvalid_q, err_q;
    logic [DataW-1:0] rdata_q;

    logic [7:0]       offset;
    logic             aligned, hit_any, hit_cfg;
    logic             hit_src, hit_dst, hit_ctrl, hit_cond, hit_irq, hit_act, hit_status;
    logic             busy, wr, rd, cfg_wr_ok, activate_go, done_evt;
    logic [DataW-1:0] rdata_d;
    logic             err_d;
    logic             unused_addr_bits;

    assign gnt_o = req_i;
    assign unused_addr_bits = ^addr_i[AddrW-1:8];

    assign offset     = addr_i[7:0];
    assign aligned    = (addr_i[1:0] == 2'b00);
    assign hit_src    = (offset == SRC_OFFSET);
    assign hit_dst    = (offset == DST_OFFSET);
    assign hit_ctrl   = (offset == CONTROL_OFFSET);
    assign hit_cond   = (offset == CONDITION_OFFSET);
    assign hit_irq    = (offset == INTERRUPT_OFFSET);
    assign hit_act    = (offset == ACTIVATE_OFFSET);
    assign hit_status = (offset == STATUS_OFFSET);
    assign hit_cfg    = hit_src | hit_dst | hit_ctrl | hit_cond;
    assign hit_any    = aligned & (hit_cfg | hit_irq | hit_act | hit_status);

    assign busy        = (state_q != IDLE);
    assign wr          = req_i & we_i & hit_any;
    assign rd          = req_i & ~we_i & hit_any;
    assign cfg_wr_ok   = wr & ~busy;
    assign activate_go = wr & hit_act & wdata_i[0] & ~busy & (len_q != '0);
    assign done_evt    = done_i & busy;

    // Response for the access presented this cycle; registered below so it
    // appears one cycle after the grant.
    always_comb begin
        rdata_d = '0;
        err_d   = 1'b0;
        if (!hit_any) begin
            err_d = 1'b1;
        end else if (we_i) begin
            err_d = (busy & hit_cfg) | (hit_act & wdata_i[0] & (busy | (len_q == '0)));
        end else begin
            if (hit_src) rdata_d = DataW'(src_q);
            if (hit_dst) rdata_d = DataW'(dst_q);
            if (hit_ctrl) begin
                rdata_d[LenW-1:0]      = len_q;
                rdata_d[CTRL_SIZE_BIT] = size_q;
            end
            if (hit_cond) begin
                rdata_d[COND_EN_BIT]   = cond_en_q;
                rdata_d[COND_TYPE_BIT] = cond_type_q;
            end
            if (hit_irq) begin
                rdata_d[IRQ_EN_BIT]      = irq_en_q;
                rdata_d[IRQ_PENDING_BIT] = irq_pending_q;
            end
            if (hit_status) begin
                rdata_d[STATUS_BUSY_BIT] = busy;
                rdata_d[STATUS_DONE_BIT] = done_q;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (activate_go) state_d = START;
            START:   state_d = done_i ? IDLE : BUSY;
            BUSY:    if (done_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Completion sets take priority over a coincident read-clear or W1C.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            src_q         <= '0;
            dst_q         <= '0;
            len_q         <= '0;
            size_q        <= SIZE_WORD;
            cond_en_q     <= 1'b0;
            cond_type_q   <= COND_LEVEL;
            irq_en_q      <= 1'b0;
            irq_pending_q <= 1'b0;
            done_q        <= 1'b0;
            irq_q         <= 1'b0;
            rvalid_q      <= 1'b0;
            err_q         <= 1'b0;
            rdata_q       <= '0;
        end else begin
            if (cfg_wr_ok & hit_src) src_q <= AddrW'(apply_be(DataW'(src_q), wdata_i, be_i));
            if (cfg_wr_ok & hit_dst) dst_q <= AddrW'(apply_be(DataW'(dst_q), wdata_i, be_i));
            if (cfg_wr_ok & hit_ctrl) begin
                len_q  <= LenW'(apply_be(DataW'(len_q), wdata_i, be_i));
                size_q <= transfer_size_t'(be_bit(size_q, wdata_i, be_i, CTRL_SIZE_BIT));
            end
            if (cfg_wr_ok & hit_cond) begin
                cond_en_q   <= be_bit(cond_en_q, wdata_i, be_i, COND_EN_BIT);
                cond_type_q <= condition_type_t'(be_bit(cond_type_q, wdata_i, be_i, COND_TYPE_BIT));
            end
            if (wr & hit_irq) irq_en_q <= be_bit(irq_en_q, wdata_i, be_i, IRQ_EN_BIT);

            if (done_evt)
                irq_pending_q <= 1'b1;
            else if (wr & hit_irq & be_i[0] & wdata_i[IRQ_PENDING_BIT])
                irq_pending_q <= 1'b0;

            if (done_evt)
                done_q <= 1'b1;
            else if (rd & hit_status)
                done_q <= 1'b0;

            irq_q    <= irq_pending_q & irq_en_q;
            rvalid_q <= req_i;
            err_q    <= req_i & err_d;
            rdata_q  <= req_i ? rdata_d : '0;
        end
    end

    assign rvalid_o    = rvalid_q;
    assign rdata_o     = rdata_q;
    assign err_o       = err_q;
    assign start_o     = (state_q == START);
    assign irq_o       = irq_q;
    assign src_addr_o  = src_q;
    assign dst_addr_o  = dst_q;
    assign len_o       = len_q;
    assign size_o      = size_q;
    assign cond_en_o   = cond_en_q;
    assign cond_type_o = cond_type_q;

endmodule

// File: tb/tb_dma_reg_if.sv
// Directed self-checking bench for dma_reg_if: register access, activation,
// busy protection, completion/interrupt behaviour and mid-transfer reset.
module tb_dma_reg_if;
    import dma_pkg::*;

    logic             clk_i = 1'b0;
    logic             rst_i;
    logic             req_i, gnt_o, we_i;
    logic [AddrW-1:0] addr_i;
    logic [3:0]       be_i;
    logic [DataW-1:0] wdata_i, rdata_o;
    logic             rvalid_o, err_o;
    logic [AddrW-1:0] src_addr_o, dst_addr_o;
    logic [15:0]      len_o;
    transfer_size_t   size_o;
    logic             cond_en_o;
    condition_type_t  cond_type_o;
    logic             start_o, done_i, irq_o;

    int n_checks = 0;
    int n_fail   = 0;

    dma_reg_if #(.LenW(16)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .req_i(req_i), .gnt_o(gnt_o), .addr_i(addr_i), .we_i(we_i), .be_i(be_i), .wdata_i(wdata_i),
        .rvalid_o(rvalid_o), .rdata_o(rdata_o), .err_o(err_o),
        .src_addr_o(src_addr_o), .dst_addr_o(dst_addr_o), .len_o(len_o), .size_o(size_o),
        .cond_en_o(cond_en_o), .cond_type_o(cond_type_o),
        .start_o(start_o), .done_i(done_i), .irq_o(irq_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // One OBI access starting just after a rising edge; returns the response.
    task automatic apply_stimulus(input logic [31:0] addr, input logic we, input logic [3:0] be,
                                  input logic [31:0] wdata, output logic [31:0] rdata, output logic err);
        req_i = 1'b1; addr_i = addr; we_i = we; be_i = be; wdata_i = wdata;
        #1 check_output("gnt", 32'(gnt_o), 32'd1);
        @(posedge clk_i); #1;
        req_i = 1'b0; we_i = 1'b0; be_i = '0; wdata_i = '0; addr_i = '0;
        check_output("rvalid", 32'(rvalid_o), 32'd1);
        rdata = rdata_o;
        err   = err_o;
    endtask

    task automatic write_reg(input string tag, input logic [7:0] off, input logic [31:0] data,
                             input logic [3:0] be, input logic exp_err);
        logic [31:0] rd;
        logic        e;
        apply_stimulus(32'(off), 1'b1, be, data, rd, e);
        check_output({tag, "_werr"}, 32'(e), 32'(exp_err));
    endtask

    task automatic read_reg(input string tag, input logic [31:0] addr, input logic [31:0] exp_data,
                            input logic exp_err);
        logic [31:0] rd;
        logic        e;
        apply_stimulus(addr, 1'b0, 4'h0, 32'h0, rd, e);
        check_output({tag, "_rdata"}, rd, exp_data);
        check_output({tag, "_rerr"}, 32'(e), 32'(exp_err));
    endtask

    task automatic pulse_done();
        done_i = 1'b1;
        @(posedge clk_i); #1;
        done_i = 1'b0;
    endtask

    initial begin
        rst_i = 1'b1; req_i = 1'b1; we_i = 1'b0; addr_i = '0; be_i = '0; wdata_i = '0; done_i = 1'b0;
        #3;
        check_output("rst_gnt", 32'(gnt_o), 32'd1);
        check_output("rst_rvalid", 32'(rvalid_o), 32'd0);
        check_output("rst_err", 32'(err_o), 32'd0);
        check_output("rst_rdata", rdata_o, 32'd0);
        check_output("rst_start", 32'(start_o), 32'd0);
        check_output("rst_irq", 32'(irq_o), 32'd0);
        req_i = 1'b0;
        #1 check_output("rst_gnt_low", 32'(gnt_o), 32'd0);
        @(posedge clk_i); #1 rst_i = 1'b0;
        @(posedge clk_i); #1;
        $display("[TB] reset released");

        // Partial byte-enable writes
        write_reg("src_be3", SRC_OFFSET, 32'h1000_0000, 4'b0011, 1'b0);
        read_reg("src_be3", 32'(SRC_OFFSET), 32'h0000_0000, 1'b0);
        check_output("src_o_be3", src_addr_o, 32'h0);
        write_reg("src_full", SRC_OFFSET, 32'h1234_5678, 4'b1111, 1'b0);
        write_reg("src_be4", SRC_OFFSET, 32'hAABB_CCDD, 4'b0100, 1'b0);
        read_reg("src_mix", 32'(SRC_OFFSET), 32'h12BB_5678, 1'b0);
        @(posedge clk_i); #1;
        check_output("idle_rvalid", 32'(rvalid_o), 32'd0);
        check_output("idle_rdata", rdata_o, 32'd0);

        // Configuration
        write_reg("ctrl_unused", CONTROL_OFFSET, 32'hFFFE_0008, 4'hF, 1'b0);
        read_reg("ctrl_unused", 32'(CONTROL_OFFSET), 32'h0000_0008, 1'b0);
        write_reg("ctrl", CONTROL_OFFSET, 32'h0001_0008, 4'hF, 1'b0);
        read_reg("ctrl", 32'(CONTROL_OFFSET), 32'h0001_0008, 1'b0);
        write_reg("cond", CONDITION_OFFSET, 32'h0000_0003, 4'hF, 1'b0);
        read_reg("cond", 32'(CONDITION_OFFSET), 32'h0000_0003, 1'b0);
        check_output("cond_en_o", 32'(cond_en_o), 32'd1);
        check_output("cond_type_o", 32'(cond_type_o), 32'd1);
        write_reg("dst", DST_OFFSET, 32'h2000_0040, 4'hF, 1'b0);
        write_reg("irq_en", INTERRUPT_OFFSET, 32'h0000_0001, 4'hF, 1'b0);
        read_reg("irq_en", 32'(INTERRUPT_OFFSET), 32'h0000_0001, 1'b0);

        // Activation
        write_reg("act", ACTIVATE_OFFSET, 32'h1, 4'hF, 1'b0);
        check_output("start_pulse", 32'(start_o), 32'd1);
        check_output("len_o", 32'(len_o), 32'd8);
        check_output("size_o", 32'(size_o), 32'(SIZE_BYTE));
        read_reg("status_busy", 32'(STATUS_OFFSET), 32'h1, 1'b0);
        check_output("start_once", 32'(start_o), 32'd0);

        // Busy protection
        write_reg("dst_busy", DST_OFFSET, 32'hDEAD_BEEF, 4'hF, 1'b1);
        check_output("dst_o_kept", dst_addr_o, 32'h2000_0040);
        write_reg("ctrl_busy", CONTROL_OFFSET, 32'h0, 4'hF, 1'b1);
        check_output("len_o_kept", 32'(len_o), 32'd8);
        write_reg("act_busy", ACTIVATE_OFFSET, 32'h1, 4'hF, 1'b1);
        check_output("no_restart", 32'(start_o), 32'd0);
        write_reg("act_zero", ACTIVATE_OFFSET, 32'h0, 4'hF, 1'b0);
        read_reg("act_read", 32'(ACTIVATE_OFFSET), 32'h0, 1'b0);
        write_reg("status_wr", STATUS_OFFSET, 32'hFFFF_FFFF, 4'hF, 1'b0);
        read_reg("status_still_busy", 32'(STATUS_OFFSET), 32'h1, 1'b0);

        // Completion and interrupt
        pulse_done();
        check_output("irq_delay", 32'(irq_o), 32'd0);
        @(posedge clk_i); #1;
        check_output("irq_set", 32'(irq_o), 32'd1);
        read_reg("status_done", 32'(STATUS_OFFSET), 32'h2, 1'b0);
        read_reg("status_cleared", 32'(STATUS_OFFSET), 32'h0, 1'b0);
        read_reg("irq_pending", 32'(INTERRUPT_OFFSET), 32'h3, 1'b0);
        write_reg("irq_w1c", INTERRUPT_OFFSET, 32'h3, 4'hF, 1'b0);
        @(posedge clk_i); #1;
        check_output("irq_cleared", 32'(irq_o), 32'd0);
        read_reg("irq_after_w1c", 32'(INTERRUPT_OFFSET), 32'h1, 1'b0);

        // Decode errors and zero-length activation
        read_reg("bad_1c", 32'h0000_001C, 32'h0, 1'b1);
        read_reg("bad_02", 32'h0000_0002, 32'h0, 1'b1);
        write_reg("bad_02", 8'h02, 32'hFFFF_FFFF, 4'hF, 1'b1);
        read_reg("src_untouched", 32'(SRC_OFFSET), 32'h12BB_5678, 1'b0);
        read_reg("upper_addr", 32'h0000_0100, 32'h12BB_5678, 1'b0);
        write_reg("len0", CONTROL_OFFSET, 32'h0, 4'hF, 1'b0);
        write_reg("act_len0", ACTIVATE_OFFSET, 32'h1, 4'hF, 1'b1);
        check_output("no_start_len0", 32'(start_o), 32'd0);
        read_reg("status_len0", 32'(STATUS_OFFSET), 32'h0, 1'b0);
        pulse_done();
        read_reg("done_idle", 32'(STATUS_OFFSET), 32'h0, 1'b0);
        read_reg("irq_idle", 32'(INTERRUPT_OFFSET), 32'h1, 1'b0);

        // done_i coinciding with the clearing STATUS read
        write_reg("ctrl4", CONTROL_OFFSET, 32'h4, 4'hF, 1'b0);
        write_reg("act2", ACTIVATE_OFFSET, 32'h1, 4'hF, 1'b0);
        @(posedge clk_i); #1;
        done_i = 1'b1;
        read_reg("status_race", 32'(STATUS_OFFSET), 32'h1, 1'b0);
        done_i = 1'b0;
        read_reg("status_set_wins", 32'(STATUS_OFFSET), 32'h2, 1'b0);
        read_reg("status_clr2", 32'(STATUS_OFFSET), 32'h0, 1'b0);

        // done_i coinciding with the irq_pending W1C
        write_reg("act3", ACTIVATE_OFFSET, 32'h1, 4'hF, 1'b0);
        done_i = 1'b1;
        write_reg("w1c_race", INTERRUPT_OFFSET, 32'h3, 4'hF, 1'b0);
        done_i = 1'b0;
        read_reg("pend_set_wins", 32'(INTERRUPT_OFFSET), 32'h3, 1'b0);

        // Reset in the middle of a transfer, with a request in flight
        write_reg("act4", ACTIVATE_OFFSET, 32'h1, 4'hF, 1'b0);
        @(posedge clk_i); #1;
        check_output("irq_before_rst", 32'(irq_o), 32'd1);
        req_i = 1'b1; addr_i = 32'(STATUS_OFFSET);
        #2 rst_i = 1'b1;
        #1;
        check_output("mid_rst_irq", 32'(irq_o), 32'd0);
        check_output("mid_rst_start", 32'(start_o), 32'd0);
        check_output("mid_rst_src", src_addr_o, 32'h0);
        check_output("mid_rst_dst", dst_addr_o, 32'h0);
        check_output("mid_rst_len", 32'(len_o), 32'd0);
        check_output("mid_rst_cond", 32'(cond_en_o), 32'd0);
        @(posedge clk_i); #1;
        check_output("mid_rst_rvalid", 32'(rvalid_o), 32'd0);
        req_i = 1'b0; addr_i = '0;
        @(posedge clk_i); #1 rst_i = 1'b0;
        @(posedge clk_i); #1;
        check_output("post_rst_rvalid", 32'(rvalid_o), 32'd0);
        read_reg("post_rst_status", 32'(STATUS_OFFSET), 32'h0, 1'b0);
        pulse_done();
        read_reg("post_rst_status2", 32'(STATUS_OFFSET), 32'h0, 1'b0);
        read_reg("post_rst_irq", 32'(INTERRUPT_OFFSET), 32'h0, 1'b0);
        read_reg("post_rst_src", 32'(SRC_OFFSET), 32'h0, 1'b0);
        check_output("post_rst_irq_o", 32'(irq_o), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
